// File: rtl/switch_conditioner.sv
// switch_conditioner: synchronizes and debounces board switches, reports changes; SWITCH_CONDITIONER_STICKY_EN adds a sticky changed flag
module switch_conditioner #(
    parameter int WIDTH = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic             change_pulse,
    output logic [WIDTH-1:0] change_mask,
    output logic             changed_flag,
    input  logic             changed_ack
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [WIDTH-1:0] sync1, sync2, sw_next;
    logic [CW-1:0] cnt [WIDTH];
    logic [CW-1:0] cnt_next [WIDTH];
    // per-bit debounce: count consecutive mismatches, accept on the last one, any match restarts
    always_comb begin
        sw_next = sw_out;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != sw_out[i]) begin
                if (cnt[i] == LAST) sw_next[i] = sync2[i];
                else cnt_next[i] = cnt[i] + 1'b1;
            end
        end
    end
    // synchronizer, debounce state and registered change report
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            sw_out <= '0;
            change_mask <= '0;
            change_pulse <= 1'b0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
            sw_out <= sw_next;
            change_mask <= sw_next ^ sw_out;
            change_pulse <= |(sw_next ^ sw_out);
            for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
        end
    end
`ifdef SWITCH_CONDITIONER_STICKY_EN
    // sticky flag: a new change wins over a simultaneous acknowledge
    always_ff @(posedge clk) begin
        if (rst) changed_flag <= 1'b0;
        else changed_flag <= (|(sw_next ^ sw_out)) | (changed_flag & ~changed_ack);
    end
`else
    logic unused_ack;
    assign unused_ack = changed_ack;
    assign changed_flag = 1'b0;
`endif
endmodule

// File: tb/tb_switch_conditioner.sv
// tb_switch_conditioner: random and directed checks of switch_conditioner against a window-based reference model
module tb_switch_conditioner;
    localparam int W = 16;
    localparam int D = 4;
`ifdef SWITCH_CONDITIONER_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic changed_ack = 1'b0;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_out, change_mask;
    logic change_pulse, changed_flag;
    int checks = 0;
    int errors = 0;
    int npulse;
    logic [W-1:0] last_mask;

    always #5 clk = ~clk;

    switch_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .sw_raw(sw_raw), .sw_out(sw_out),
        .change_pulse(change_pulse), .change_mask(change_mask),
        .changed_flag(changed_flag), .changed_ack(changed_ack)
    );

    // reference: a bit flips once the last D synchronized samples since reset all disagree with it
    logic [W-1:0] m_s1, m_s2, m_out, m_mask, m_nxt;
    logic m_pulse, m_flag;
    logic [W-1:0] hist[$];
    bit all_diff;
    always @(posedge clk) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_out = '0; m_mask = '0; m_pulse = 1'b0; m_flag = 1'b0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > D) void'(hist.pop_front());
            m_nxt = m_out;
            if (hist.size() == D)
                for (int b = 0; b < W; b++) begin
                    all_diff = 1'b1;
                    foreach (hist[k]) if (hist[k][b] == m_out[b]) all_diff = 1'b0;
                    if (all_diff) m_nxt[b] = ~m_out[b];
                end
            m_mask = m_nxt ^ m_out;
            m_pulse = m_mask != '0;
            m_flag = STICKY && (m_pulse || (m_flag && !changed_ack));
            m_out = m_nxt;
            m_s2 = m_s1;
            m_s1 = sw_raw;
        end
    end

    task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // one clock, then compare every output with the model
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("sw_out", sw_out, m_out);
        chk("change_pulse", W'(change_pulse), W'(m_pulse));
        chk("change_mask", change_mask, m_mask);
        chk("changed_flag", W'(changed_flag), W'(m_flag));
        if (change_pulse) begin
            npulse++;
            last_mask = change_mask;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        sw_raw = '0;
        tick();
        tick();
        chk("reset_sw_out", sw_out, 16'h0000);
        chk("reset_pulse", W'(change_pulse), 16'h0000);
        chk("reset_mask", change_mask, 16'h0000);
        chk("reset_flag", W'(changed_flag), 16'h0000);
        rst = 1'b0;
        tick();
        sw_raw = 16'h0001;
        repeat (5) tick();
        chk("latency_edge5", sw_out, 16'h0000);
        tick();
        chk("latency_edge6_sw", sw_out, 16'h0001);
        chk("latency_edge6_pulse", W'(change_pulse), 16'h0001);
        chk("latency_edge6_mask", change_mask, 16'h0001);
        tick();
        chk("latency_edge7_pulse", W'(change_pulse), 16'h0000);
        chk("latency_edge7_mask", change_mask, 16'h0000);

        do_reset();
        sw_raw = '0;
        tick();
        npulse = 0;
        sw_raw = 16'h0008;
        repeat (3) tick();
        sw_raw = '0;
        repeat (10) tick();
        chk("glitch_sw", sw_out, 16'h0000);
        chk("glitch_pulses", W'(npulse), 16'h0000);

        npulse = 0;
        sw_raw = 16'h8081;
        repeat (12) tick();
        chk("multi_pulses", W'(npulse), 16'h0001);
        chk("multi_mask", last_mask, 16'h8081);
        chk("multi_sw", sw_out, 16'h8081);

        do_reset();
        sw_raw = '0;
        tick();
        sw_raw = 16'h00FF;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_sw", sw_out, 16'h0000);
        chk("mid_rst_pulse", W'(change_pulse), 16'h0000);
        chk("mid_rst_mask", change_mask, 16'h0000);
        rst = 1'b0;
        npulse = 0;
        repeat (5) tick();
        chk("mid_rst_edge5", sw_out, 16'h0000);
        tick();
        chk("mid_rst_edge6_sw", sw_out, 16'h00FF);
        chk("mid_rst_edge6_pulse", W'(change_pulse), 16'h0001);
        chk("mid_rst_pulses", W'(npulse), 16'h0001);

        sw_raw = 16'h0F00;
        repeat (6) tick();
        chk("sticky_set", W'(changed_flag), W'(STICKY));
        repeat (10) begin
            tick();
            chk("sticky_hold", W'(changed_flag), W'(STICKY));
        end
        changed_ack = 1'b1;
        tick();
        changed_ack = 1'b0;
        chk("sticky_ack_clear", W'(changed_flag), 16'h0000);
        sw_raw = 16'h0000;
        repeat (5) tick();
        changed_ack = 1'b1;
        tick();
        changed_ack = 1'b0;
        chk("sticky_set_wins_pulse", W'(change_pulse), 16'h0001);
        chk("sticky_set_wins", W'(changed_flag), W'(STICKY));
        tick();
        chk("sticky_still_set", W'(changed_flag), W'(STICKY));
        changed_ack = 1'b1;
        tick();
        changed_ack = 1'b0;
        chk("sticky_lone_ack", W'(changed_flag), 16'h0000);

        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(((c / 500) % 2 == 0) ? 20 : 4) == 0) sw_raw[b] = ~sw_raw[b];
            changed_ack = $urandom_range(7) == 0;
            rst = $urandom_range(299) == 0;
            tick();
        end
        rst = 1'b0;
        changed_ack = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
